prog_data_ram: RTL and testbench

PROG_DATA_RAM -- requirements
Module: prog_data_ram

---
 rtl/prog_data_ram.sv | 140 ++++++++++++++
 tb/tb_prog_data_ram.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/prog_data_ram.sv
// prog_data_ram: small program store loaded from switches by a step button,
// reviewed in CHECK mode, and mapped together with a data store onto the
// CPU address bus in RUN mode.
module prog_data_ram #(
  parameter int DATA_W  = 8,
  parameter int ADDR_W  = 16,
  parameter int PROG_AW = 5,
  parameter int DATA_AW = 10
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [1:0]        cpustate,
  input  logic              A1,
  input  logic [DATA_W-1:0] D,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] data_in,
  input  logic              read,
  input  logic              write,
  output logic [DATA_W-1:0] data_out,
  output logic              rd_valid,
  output logic              wr_err,
  output logic [DATA_W-1:0] check_out,
  output logic [PROG_AW-1:0] ptr,
  output logic              prog_full
);

  localparam int PROG_DEPTH = 2 ** PROG_AW;
  localparam int DATA_DEPTH = 2 ** DATA_AW;
  localparam logic [ADDR_W-1:0] PROG_BASE = ADDR_W'(1) << PROG_AW;
  localparam logic [PROG_AW-1:0] PTR_LAST = {PROG_AW{1'b1}};

  typedef enum logic [1:0] {
    MODE_IDLE  = 2'b00,
    MODE_IN    = 2'b01,
    MODE_CHECK = 2'b10,
    MODE_RUN   = 2'b11
  } mode_t;

  mode_t mode;
  mode_t prev_mode;

  logic [DATA_W-1:0] prog_mem [PROG_DEPTH];
  logic [DATA_W-1:0] data_mem [DATA_DEPTH];

  logic a1_s1, a1_s2, a1_s3;
  logic press;
  logic mode_change;
  logic in_prog;
  logic [PROG_AW-1:0] prog_addr;
  logic [DATA_AW-1:0] data_addr;
  logic prog_we;
  logic run_rd;
  logic run_wr;

  assign mode        = mode_t'(cpustate);
  assign mode_change = (mode != prev_mode);

  // Press is a falling edge of the synchronized button (s2 low, s3 still high)
  assign press = a1_s3 & ~a1_s2;

  // RUN address decode: low window is the program store, the rest wraps over data
  assign in_prog   = (addr < PROG_BASE);
  assign prog_addr = addr[PROG_AW-1:0];
  assign data_addr = DATA_AW'(addr - PROG_BASE);

  assign prog_we = (mode == MODE_IN) && press && !mode_change && !prog_full;
  assign run_rd  = (mode == MODE_RUN) && read;
  assign run_wr  = (mode == MODE_RUN) && write;

  assign check_out = (mode == MODE_CHECK) ? prog_mem[ptr] : '0;

  // Two-flop synchronizer plus edge-detect history for the button; idles high
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      a1_s1 <= 1'b1;
      a1_s2 <= 1'b1;
      a1_s3 <= 1'b1;
    end else begin
      a1_s1 <= A1;
      a1_s2 <= a1_s1;
      a1_s3 <= a1_s2;
    end
  end

  // Pointer and load-complete flag; a mode change wins over a press that cycle
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      prev_mode <= MODE_IDLE;
      ptr       <= '0;
      prog_full <= 1'b0;
    end else begin
      prev_mode <= mode;
      if (mode_change) begin
        ptr <= '0;
        if (mode == MODE_IN) begin
          prog_full <= 1'b0;
        end
      end else if (press) begin
        if (mode == MODE_IN && !prog_full) begin
          ptr <= ptr + PROG_AW'(1);
          if (ptr == PTR_LAST) begin
            prog_full <= 1'b1;
          end
        end else if (mode == MODE_CHECK) begin
          ptr <= ptr + PROG_AW'(1);
        end
      end
    end
  end

  // CPU read port and write-error pulse; reads see contents before this edge's write
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      data_out <= '0;
      rd_valid <= 1'b0;
      wr_err   <= 1'b0;
    end else begin
      rd_valid <= 1'b0;
      wr_err   <= 1'b0;
      if (run_rd) begin
        data_out <= in_prog ? prog_mem[prog_addr] : data_mem[data_addr];
        rd_valid <= 1'b1;
      end
      if (run_wr && in_prog) begin
        wr_err <= 1'b1;
      end
    end
  end

  // Storage arrays are deliberately not reset so a reset mid-load keeps earlier words
  always_ff @(posedge clk) begin
    if (prog_we) begin
      prog_mem[ptr] <= D;
    end
    if (run_wr && !in_prog) begin
      data_mem[data_addr] <= data_in;
    end
  end

endmodule

// File: tb/tb_prog_data_ram.sv
// tb_prog_data_ram: directed self-checking bench for prog_data_ram.
module tb_prog_data_ram;

  logic        clk;
  logic        reset;
  logic [1:0]  cpustate;
  logic        A1;
  logic [7:0]  D;
  logic [15:0] addr;
  logic [7:0]  data_in;
  logic        read;
  logic        write;
  logic [7:0]  data_out;
  logic        rd_valid;
  logic        wr_err;
  logic [7:0]  check_out;
  logic [4:0]  ptr;
  logic        prog_full;

  int checks = 0;
  int passed = 0;

  prog_data_ram #(
    .DATA_W(8), .ADDR_W(16), .PROG_AW(5), .DATA_AW(10)
  ) dut (
    .clk(clk), .reset(reset), .cpustate(cpustate), .A1(A1), .D(D),
    .addr(addr), .data_in(data_in), .read(read), .write(write),
    .data_out(data_out), .rd_valid(rd_valid), .wr_err(wr_err),
    .check_out(check_out), .ptr(ptr), .prog_full(prog_full)
  );

  // 100 MHz free-running clock
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Hold the button down long enough to be seen, then release and settle
  task automatic do_press();
    A1 = 1'b0;
    repeat (6) @(negedge clk);
    A1 = 1'b1;
    repeat (6) @(negedge clk);
  endtask

  task automatic set_mode(input logic [1:0] m);
    cpustate = m;
    repeat (2) @(negedge clk);
  endtask

  // Single-cycle CPU access issued at a negedge, results visible at the next negedge
  task automatic cpu_access(input logic [15:0] a, input logic [7:0] wd,
                            input logic rd, input logic wr);
    addr = a; data_in = wd; read = rd; write = wr;
    @(negedge clk);
    read = 1'b0; write = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1; cpustate = 2'b00; A1 = 1'b1; D = '0;
    addr = '0; data_in = '0; read = 1'b0; write = 1'b0;
    repeat (3) @(negedge clk);
    checks++; if (ptr !== 5'd0) $display("[TB] FAIL reset_ptr: got %0d expected 0", ptr); else passed++;
    checks++; if (prog_full !== 1'b0) $display("[TB] FAIL reset_full: got %b expected 0", prog_full); else passed++;
    checks++; if (data_out !== 8'h00) $display("[TB] FAIL reset_dout: got %h expected 00", data_out); else passed++;
    checks++; if (rd_valid !== 1'b0) $display("[TB] FAIL reset_rdv: got %b expected 0", rd_valid); else passed++;
    checks++; if (wr_err !== 1'b0) $display("[TB] FAIL reset_werr: got %b expected 0", wr_err); else passed++;
    reset = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_load();
    set_mode(2'b01);
    for (int i = 0; i < 32; i++) begin
      D = 8'h10 + 8'(i);
      do_press();
      if (i == 0) begin
        checks++; if (ptr !== 5'd1) $display("[TB] FAIL load_first_ptr: got %0d expected 1", ptr); else passed++;
        checks++; if (prog_full !== 1'b0) $display("[TB] FAIL load_first_full: got %b expected 0", prog_full); else passed++;
      end
    end
    checks++; if (prog_full !== 1'b1) $display("[TB] FAIL load_full: got %b expected 1", prog_full); else passed++;
    checks++; if (ptr !== 5'd0) $display("[TB] FAIL load_wrap_ptr: got %0d expected 0", ptr); else passed++;
    checks++; if (check_out !== 8'h00) $display("[TB] FAIL check_out_in_mode: got %h expected 00", check_out); else passed++;
    D = 8'hEE;
    do_press();
    checks++; if (ptr !== 5'd0) $display("[TB] FAIL load_extra_ptr: got %0d expected 0", ptr); else passed++;
    checks++; if (prog_full !== 1'b1) $display("[TB] FAIL load_extra_full: got %b expected 1", prog_full); else passed++;
  endtask

  task automatic test_check();
    set_mode(2'b10);
    checks++; if (ptr !== 5'd0) $display("[TB] FAIL check_entry_ptr: got %0d expected 0", ptr); else passed++;
    checks++; if (check_out !== 8'h10) $display("[TB] FAIL check_word0: got %h expected 10", check_out); else passed++;
    repeat (3) do_press();
    checks++; if (ptr !== 5'd3) $display("[TB] FAIL check_ptr3: got %0d expected 3", ptr); else passed++;
    checks++; if (check_out !== 8'h13) $display("[TB] FAIL check_word3: got %h expected 13", check_out); else passed++;
    repeat (32) do_press();
    checks++; if (ptr !== 5'd3) $display("[TB] FAIL check_wrap_ptr: got %0d expected 3", ptr); else passed++;
    checks++; if (check_out !== 8'h13) $display("[TB] FAIL check_wrap_word: got %h expected 13", check_out); else passed++;
  endtask

  task automatic test_run();
    set_mode(2'b11);
    cpu_access(16'h0020, 8'hA5, 1'b0, 1'b1);
    checks++; if (wr_err !== 1'b0) $display("[TB] FAIL run_data_wr_err: got %b expected 0", wr_err); else passed++;
    cpu_access(16'h0020, 8'h00, 1'b1, 1'b0);
    checks++; if (data_out !== 8'hA5) $display("[TB] FAIL run_rd_data: got %h expected A5", data_out); else passed++;
    checks++; if (rd_valid !== 1'b1) $display("[TB] FAIL run_rd_valid: got %b expected 1", rd_valid); else passed++;
    @(negedge clk);
    checks++; if (rd_valid !== 1'b0) $display("[TB] FAIL run_rd_pulse: got %b expected 0", rd_valid); else passed++;
    checks++; if (data_out !== 8'hA5) $display("[TB] FAIL run_rd_hold: got %h expected A5", data_out); else passed++;
    cpu_access(16'h0004, 8'h77, 1'b0, 1'b1);
    checks++; if (wr_err !== 1'b1) $display("[TB] FAIL run_wr_err: got %b expected 1", wr_err); else passed++;
    @(negedge clk);
    checks++; if (wr_err !== 1'b0) $display("[TB] FAIL run_wr_err_pulse: got %b expected 0", wr_err); else passed++;
    cpu_access(16'h0004, 8'h00, 1'b1, 1'b0);
    checks++; if (data_out !== 8'h14) $display("[TB] FAIL run_prog4: got %h expected 14", data_out); else passed++;
    cpu_access(16'h0020, 8'h5A, 1'b1, 1'b1);
    checks++; if (data_out !== 8'hA5) $display("[TB] FAIL run_rbw_old: got %h expected A5", data_out); else passed++;
    cpu_access(16'h0420, 8'h00, 1'b1, 1'b0);
    checks++; if (data_out !== 8'h5A) $display("[TB] FAIL run_data_wrap: got %h expected 5A", data_out); else passed++;
    cpu_access(16'h001F, 8'h00, 1'b1, 1'b0);
    checks++; if (data_out !== 8'h2F) $display("[TB] FAIL run_prog_last: got %h expected 2F", data_out); else passed++;
    set_mode(2'b00);
    cpu_access(16'h0020, 8'h00, 1'b1, 1'b1);
    checks++; if (rd_valid !== 1'b0) $display("[TB] FAIL idle_rd_valid: got %b expected 0", rd_valid); else passed++;
    checks++; if (wr_err !== 1'b0) $display("[TB] FAIL idle_wr_err: got %b expected 0", wr_err); else passed++;
    checks++; if (data_out !== 8'h2F) $display("[TB] FAIL idle_dout_hold: got %h expected 2F", data_out); else passed++;
    set_mode(2'b11);
    cpu_access(16'h0020, 8'h00, 1'b1, 1'b0);
    checks++; if (data_out !== 8'h5A) $display("[TB] FAIL idle_no_write: got %h expected 5A", data_out); else passed++;
  endtask

  task automatic test_coincident();
    set_mode(2'b01);
    D = 8'h10;
    do_press();
    checks++; if (ptr !== 5'd1) $display("[TB] FAIL coin_pre_ptr: got %0d expected 1", ptr); else passed++;
    D = 8'h99;
    A1 = 1'b0;
    @(negedge clk);
    @(negedge clk);
    cpustate = 2'b10;
    @(negedge clk);
    A1 = 1'b1;
    repeat (6) @(negedge clk);
    checks++; if (ptr !== 5'd0) $display("[TB] FAIL coin_ptr: got %0d expected 0", ptr); else passed++;
    checks++; if (check_out !== 8'h10) $display("[TB] FAIL coin_word0: got %h expected 10", check_out); else passed++;
    do_press();
    checks++; if (check_out !== 8'h11) $display("[TB] FAIL coin_no_write: got %h expected 11", check_out); else passed++;
  endtask

  task automatic test_long_press();
    A1 = 1'b0;
    repeat (100) @(negedge clk);
    A1 = 1'b1;
    repeat (6) @(negedge clk);
    checks++; if (ptr !== 5'd2) $display("[TB] FAIL long_press_ptr: got %0d expected 2", ptr); else passed++;
    A1 = 1'b0;
    repeat (10) @(negedge clk);
    reset = 1'b1;
    cpustate = 2'b00;
    @(negedge clk);
    checks++; if (ptr !== 5'd0) $display("[TB] FAIL midpress_reset_ptr: got %0d expected 0", ptr); else passed++;
    reset = 1'b0;
    repeat (10) @(negedge clk);
    cpustate = 2'b10;
    repeat (3) @(negedge clk);
    A1 = 1'b1;
    repeat (10) @(negedge clk);
    checks++; if (ptr !== 5'd0) $display("[TB] FAIL release_no_event: got %0d expected 0", ptr); else passed++;
    checks++; if (check_out !== 8'h10) $display("[TB] FAIL mem_kept_on_reset: got %h expected 10", check_out); else passed++;
  endtask

  // Run all scenarios in order; each builds on the memory state left by the previous one
  initial begin
    test_reset();
    test_load();
    test_check();
    test_run();
    test_coincident();
    test_long_press();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
